dlfloat_mac_seq: RTL and testbench
==================================

# dlfloat_mac_seq

Job sequencer for the DLFloat16 multiply-accumulate datapath. It accepts a dot-product job of `cfg_len` operand pairs and clears the MAC accumulator. It then feeds the pairs through a valid/ready stream, waits out the MAC pipeline, and returns the accumulated DLFloat16 result on a valid/ready output. It sits between the byte-level I/O wrappers and `dlfloat_mac`, and replaces free-running accumulation with bounded, restartable jobs.

## Interface
Parameters:
- `LEN_W`, 4: width of the job-length field; maximum job is 2^LEN_W−1 pairs.
- `MAC_LAT`, 2: clock edges from an operand pair appearing on `mac_a`/`mac_b` to the accumulator reflecting it (multiplier register plus accumulator register).

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  job request; sampled only in IDLE
- `cfg_len`  in  LEN_W  number of pairs; captured on the accepted `start`
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  operand pair accepted this cycle when high together with `in_valid`
- `in_a`, `in_b`  in  16  DLFloat16 operands {sign, exp[5:0] bias 31, mant[8:0]}
- `mac_a`, `mac_b`  out  16  registered operands to the MAC
- `mac_clr`  out  1  accumulator synchronous clear to the MAC
- `mac_acc`  in  16  MAC accumulator value
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed
- `out_data`  out  16  captured result
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  sticky special-operand flag (see Configuration)

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, HOLD.
- IDLE: `in_ready`=0. `start`=1 captures `cfg_len` into `len_q`, loads `clr_cnt`=MAC_LAT and moves to CLEAR.
- CLEAR: `mac_clr`=1 and `mac_a`=`mac_b`=0. `clr_cnt` decrements each cycle. When `clr_cnt` reaches 1:
  - `len_q`≠0: move to FEED.
  - `len_q`=0: move to DRAIN.
- FEED: `in_ready`=1.
  - On a handshake, register `in_a`/`in_b` into `mac_a`/`mac_b` and decrement `len_q`.
  - With no handshake, drive `mac_a`=`mac_b`=0. A zero product leaves the accumulator unchanged.
  - The handshake that brings `len_q` to 0 moves to DRAIN with `drn_cnt`=MAC_LAT.
- DRAIN: `in_ready`=0 and operands are zero. `drn_cnt` decrements. At 0, capture `mac_acc` into `out_data`, set `out_valid`=1 and move to HOLD.
- HOLD: `out_valid`=1 and `out_data` stays stable until `out_valid`&&`out_ready`. Then clear `out_valid` and return to IDLE.
- `start` outside IDLE is ignored and not queued. `in_valid` outside FEED is ignored.
- Counters are unsigned, with no wrap. `len_q` never decrements below 0.
- Reset values: `in_ready`=0, `mac_a`=`mac_b`=0, `mac_clr`=0, `out_valid`=0, `out_data`=0, `busy`=0, `err`=0, state IDLE.
- Reset mid-job aborts immediately to IDLE. Nothing is drained and the partial result is discarded. The MAC is cleared by the next job's CLEAR.

## Timing
- Accepted `start` at edge s: `mac_clr` is high for cycles s..s+MAC_LAT−1, and `in_ready` rises at edge s+MAC_LAT.
- Handshake at edge k: `mac_a`/`mac_b` are valid from k to k+1, and the accumulator reflects the pair at edge k+MAC_LAT.
- Last handshake at edge k: `out_valid` rises at edge k+MAC_LAT+1.
- Zero-length job: `out_valid` rises at edge s+2·MAC_LAT+1 with `out_data`=0x0000.
- Throughput is one pair per cycle in FEED.
- Minimum job-to-job gap: one IDLE cycle after the `out_ready` handshake.

## Configuration
- `DLFMAC_SEQ_NAN_STICKY_EN` defined:
  - `err` sets on any FEED handshake with `in_a`==0xFFFF or `in_b`==0xFFFF.
  - `err` is held through HOLD and cleared when the job leaves HOLD or on the next accepted `start`.
- Not defined: `err` is tied to 0 and no detection logic is built.

## Structure
- Shared package `dlfloat_pkg`:
  - state enum `seq_state_t`
  - `DLF_NAN`=16'hFFFF
  - `DLF_ZERO`=16'h0000
  - `DLF_ONE`=16'h3E00
  - field widths `DLF_EXP_W`=6 and `DLF_MAN_W`=9
- Optional sub-module `dlfloat_seq_cnt`: a loadable down-counter with zero flag, instantiated for `len_q`, `clr_cnt` and `drn_cnt`.
- `dlfloat_mac` gains the `mac_clr` input; `dlfloat_mac_seq` instantiates neither the MAC nor the I/O wrappers.

## Test plan
- Single pair: `cfg_len`=1 with `in_a`=`in_b`=0x3E00 (1.0) → `out_data`=0x3E00, with `out_valid` exactly MAC_LAT+1 edges after the handshake.
- Two pairs of 1.0×1.0: `cfg_len`=2 → `out_data`=0x4000 (2.0). A second identical job after it also yields 0x4000, confirming the clear.
- Backpressure: `cfg_len`=3 with `in_valid` dropped for 2 cycles between pairs, and `out_ready` held low 4 cycles → same result as without gaps. `out_data` is stable while held and `in_ready` is 0 outside FEED.
- Zero length: `cfg_len`=0 → `out_data`=0x0000 at s+2·MAC_LAT+1, and `in_ready` never high.
- Abuse: `start` pulsed during FEED is ignored. `rst_n` low mid-FEED → all outputs at reset values next cycle, and a fresh 1-pair job returns 0x3E00.
- Macro on: a pair with `in_a`=0xFFFF → `err`=1 through HOLD and 0 after the `out_ready` handshake. Macro off: `err` stays 0.

Source files
------------

// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlfloat_pkg : shared DLFloat16 constants and sequencer state type
// Rev 1.0
// ---------------------------------------------------------------------------
package dlfloat_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } seq_state_t;

   localparam logic [15:0] DLF_NAN  = 16'hFFFF;
   localparam logic [15:0] DLF_ZERO = 16'h0000;
   localparam logic [15:0] DLF_ONE  = 16'h3E00;
   localparam int          DLF_EXP_W = 6;
   localparam int          DLF_MAN_W = 9;

   function automatic logic is_dlf_nan(input logic [15:0] v);
      return (v == DLF_NAN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dlfloat_seq_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlfloat_seq_cnt : loadable saturating down-counter with zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module dlfloat_seq_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // load wins over dec; dec never wraps below zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/dlfloat_mac_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dlfloat_mac_seq : bounded dot-product job sequencer for the DLFloat16 MAC
// Optional NaN sticky flag: DLFMAC_SEQ_NAN_STICKY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module dlfloat_mac_seq
   import dlfloat_pkg::*;
#(
   parameter int LEN_W   = 4,
   parameter int MAC_LAT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic             mac_clr,
   input  logic [15:0]      mac_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic             busy,
   output logic             err
);

   localparam int               CNT_W = $clog2(MAC_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_V = CNT_W'(MAC_LAT);

   seq_state_t state, state_nxt;

   logic             len_load, len_dec, len_zero;
   logic             clr_load, clr_dec, clr_zero;
   logic             drn_load, drn_dec, drn_zero;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] clr_cnt, drn_cnt;
   logic             hs;

   assign hs       = (state == S_FEED) && in_valid;
   assign in_ready = (state == S_FEED);
   assign mac_clr  = (state == S_CLEAR);
   assign busy     = (state != S_IDLE);

   dlfloat_seq_cnt #(.W(LEN_W)) u_len_cnt (
      .clk(clk), .rst_n(rst_n), .load(len_load), .load_val(cfg_len),
      .dec(len_dec), .cnt(len_q), .zero(len_zero)
   );

   dlfloat_seq_cnt #(.W(CNT_W)) u_clr_cnt (
      .clk(clk), .rst_n(rst_n), .load(clr_load), .load_val(LAT_V),
      .dec(clr_dec), .cnt(clr_cnt), .zero(clr_zero)
   );

   dlfloat_seq_cnt #(.W(CNT_W)) u_drn_cnt (
      .clk(clk), .rst_n(rst_n), .load(drn_load), .load_val(LAT_V),
      .dec(drn_dec), .cnt(drn_cnt), .zero(drn_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      len_load  = 1'b0;
      len_dec   = 1'b0;
      clr_load  = 1'b0;
      clr_dec   = 1'b0;
      drn_load  = 1'b0;
      drn_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               len_load  = 1'b1;
               clr_load  = 1'b1;
               state_nxt = S_CLEAR;
            end
         end
         S_CLEAR: begin
            clr_dec = 1'b1;
            // zero check guards against a degenerate latency setting
            if ((clr_cnt == CNT_W'(1)) || clr_zero) begin
               if (len_zero) begin
                  drn_load  = 1'b1;
                  state_nxt = S_DRAIN;
               end else begin
                  state_nxt = S_FEED;
               end
            end
         end
         S_FEED: begin
            if (hs) begin
               len_dec = 1'b1;
               if (len_q == LEN_W'(1)) begin
                  drn_load  = 1'b1;
                  state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            drn_dec = 1'b1;
            if (drn_zero)
               state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // idle cycles feed zero operands so the accumulator is left untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_a <= DLF_ZERO;
         mac_b <= DLF_ZERO;
      end else if (hs) begin
         mac_a <= in_a;
         mac_b <= in_b;
      end else begin
         mac_a <= DLF_ZERO;
         mac_b <= DLF_ZERO;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= DLF_ZERO;
      end else if ((state == S_DRAIN) && drn_zero) begin
         out_valid <= 1'b1;
         out_data  <= mac_acc;
      end else if ((state == S_HOLD) && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DLFMAC_SEQ_NAN_STICKY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err <= 1'b0;
      else if ((state == S_IDLE) && start)
         err <= 1'b0;
      else if (hs && (is_dlf_nan(in_a) || is_dlf_nan(in_b)))
         err <= 1'b1;
      else if ((state == S_HOLD) && out_ready)
         err <= 1'b0;
   end
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_mac_seq.sv
`default_nettype none
// Bench for dlfloat_mac_seq: integer-valued DLFloat16 jobs checked against
// exact dot-product sums, with a behavioural two-stage MAC on the far side.
module tb_dlfloat_mac_seq;
   import dlfloat_pkg::*;

   localparam int LEN_W   = 4;
   localparam int MAC_LAT = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_a = 16'h0;
   logic [15:0]      in_b = 16'h0;
   logic [15:0]      mac_a, mac_b, mac_acc, out_data;
   logic             mac_clr, out_valid, busy, err;
   logic             out_ready = 1'b0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   dlfloat_mac_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // exact conversions for small integer values
   function automatic longint dlf_to_int(input logic [15:0] v);
      longint m;
      int     sh;
      if (v[14:0] == 15'h0 || v[14:9] == 6'h3F) return 0;
      m  = 512 + longint'(v[8:0]);
      sh = int'(v[14:9]) - 40;
      if (sh >= 0) m = m << sh;
      else         m = m >> (-sh);
      return v[15] ? -m : m;
   endfunction

   function automatic logic [15:0] int_to_dlf(input longint n);
      longint      m;
      int          p;
      logic [15:0] r;
      if (n == 0) return 16'h0000;
      m = (n < 0) ? -n : n;
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      r[15]   = (n < 0);
      r[14:9] = 6'(31 + p);
      if (p <= 9) r[8:0] = 9'((m << (9 - p)) & 511);
      else        r[8:0] = 9'((m >> (p - 9)) & 511);
      return r;
   endfunction

   // external MAC: product register then accumulator register, sync clear
   longint prod_m = 0;
   longint acc_m  = 0;
   always @(posedge clk) begin
      prod_m <= mac_clr ? 0 : dlf_to_int(mac_a) * dlf_to_int(mac_b);
      acc_m  <= mac_clr ? 0 : acc_m + prod_m;
   end
   assign mac_acc = int_to_dlf(acc_m);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_job(input int len, input int gap, input int hold,
                          input bit poke_start, input bit nan_first,
                          input bit fixed, input bit chk_data);
      longint      sum;
      int          s, k, n, ai, bi, ref_edge, exp_lat;
      logic [15:0] a, b, held;
      bit          nan_exp;
`ifdef DLFMAC_SEQ_NAN_STICKY_EN
      nan_exp = nan_first;
`else
      nan_exp = 1'b0;
`endif
      sum = 0;
      k   = 0;
      start = 1'b1; cfg_len = LEN_W'(len);
      step();
      s = cyc; start = 1'b0;
      for (int i = 0; i < MAC_LAT; i++) begin
         chk("clear_mac_clr", mac_clr, 1);
         chk("clear_in_ready", in_ready, 0);
         chk("clear_busy", busy, 1);
         step();
      end
      chk("after_clear_mac_clr", mac_clr, 0);
      chk("after_clear_in_ready", in_ready, (len != 0) ? 1 : 0);
      for (int i = 0; i < len; i++) begin
         for (int g = 0; g < ((i > 0) ? gap : 0); g++) begin
            in_valid = 1'b0;
            step();
            chk("gap_in_ready", in_ready, 1);
            chk("gap_mac_a_zero", mac_a, 0);
         end
         if (fixed) begin ai = 1; bi = 1; end
         else begin
            ai = int'($urandom_range(14, 0)) - 7;
            bi = int'($urandom_range(14, 0)) - 7;
         end
         a = int_to_dlf(ai);
         b = int_to_dlf(bi);
         if (nan_first && i == 0) a = DLF_NAN;
         else sum += longint'(ai) * longint'(bi);
         in_a = a; in_b = b; in_valid = 1'b1;
         chk("feed_in_ready", in_ready, 1);
         if (poke_start && i == 0) begin start = 1'b1; cfg_len = LEN_W'(5); end
         step();
         k = cyc;
         in_valid = 1'b0; start = 1'b0;
         in_a = 16'($urandom); in_b = 16'($urandom);
         chk("mac_a_reg", mac_a, a);
         chk("mac_b_reg", mac_b, b);
      end
      ref_edge = (len == 0) ? s : k;
      exp_lat  = (len == 0) ? 2 * MAC_LAT + 1 : MAC_LAT + 1;
      n = 0;
      while (!out_valid && n < 20) begin
         chk("drain_in_ready", in_ready, 0);
         in_valid = 1'b1;
         step();
         n++;
      end
      in_valid = 1'b0;
      chk("out_valid_seen", out_valid, 1);
      chk("result_latency", cyc - ref_edge, exp_lat);
      held = out_data;
      if (chk_data) chk("result_data", out_data, int_to_dlf(sum));
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_data_stable", out_data, held);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_err", err, nan_exp);
      end
      chk("pre_release_err", err, nan_exp);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release_valid", out_valid, 0);
      chk("release_busy", busy, 0);
      chk("release_err", err, 0);
      step();
      chk("idle_gap_busy", busy, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      run_job(1, 0, 0, 0, 0, 1, 1);
      chk("single_pair_one", out_data, DLF_ONE);
      run_job(2, 0, 1, 0, 0, 1, 1);
      chk("two_pairs_two", out_data, 16'h4000);
      run_job(2, 0, 0, 0, 0, 1, 1);
      chk("two_pairs_again", out_data, 16'h4000);
      run_job(3, 2, 4, 0, 0, 0, 1);
      run_job(0, 0, 1, 0, 0, 0, 1);
      chk("zero_len_data", out_data, DLF_ZERO);
      for (int j = 0; j < 4; j++)
         run_job(int'($urandom_range(15, 1)), int'($urandom_range(1, 0)),
                 int'($urandom_range(2, 0)), 0, 0, 0, 1);
      run_job(4, 1, 1, 1, 0, 0, 1);
      run_job(15, 0, 0, 0, 0, 0, 1);

      // abort a job mid-feed
      start = 1'b1; cfg_len = LEN_W'(3);
      step();
      start = 1'b0;
      step();
      step();
      in_a = DLF_ONE; in_b = DLF_ONE; in_valid = 1'b1;
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_mac_a", mac_a, 0);
      chk("abort_mac_b", mac_b, 0);
      chk("abort_mac_clr", mac_clr, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out_data", out_data, 0);
      chk("abort_busy", busy, 0);
      chk("abort_err", err, 0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      run_job(1, 0, 0, 0, 0, 1, 1);
      chk("post_abort_one", out_data, DLF_ONE);

      run_job(2, 0, 2, 0, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
